// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared widths, ALU op codes and arbiter state encodings
package alu_arbiter_pkg;

    localparam int DATA_BUS_WIDTH  = 16;
    localparam int ALU_OP_NUM_BITS = 3;

    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_ADD = 3'd0;
    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_SUB = 3'd1;
    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_AND = 3'd2;
    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_OR  = 3'd3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin picker: first valid at or after ptr, wrapping
module alu_arbiter_rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDXW-1:0]    ptr,
    output logic [IDXW-1:0]    grant,
    output logic               any
);

    int idx;

    // Scan farthest-to-nearest so the candidate closest to ptr is the last one written.
    always_comb begin
        grant = '0;
        any   = |valid;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[IDXW'(idx)]) begin
                grant = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among NUM_REQ requesters
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]    req_b,
    input  logic [NUM_REQ*ALU_OP_NUM_BITS-1:0]   req_op,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    input  logic [NUM_REQ-1:0]                   rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0]            rsp_result,
    output logic                                 rsp_z,
    output logic [DATA_BUS_WIDTH-1:0]            alu_a,
    output logic [DATA_BUS_WIDTH-1:0]            alu_b,
    output logic [ALU_OP_NUM_BITS-1:0]           alu_op,
    input  logic [DATA_BUS_WIDTH-1:0]            alu_result,
    input  logic                                 alu_z
);

    arb_state_e      state;
    arb_state_e      state_next;
    logic [IDXW-1:0] grant;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] pick;
    logic            any;

    alu_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick),
        .any   (any)
    );

    // Ready is gated by reset so a requester never sees an accept while the block is held in reset.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            ARB_IDLE: begin
                if (any && reset_n) begin
                    req_ready[pick] = 1'b1;
                    state_next      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: state_next = ARB_RESP;
            ARB_RESP: begin
                if (rsp_ready[grant]) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_z      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        alu_a  <= req_a[pick*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
                        alu_b  <= req_b[pick*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
                        alu_op <= req_op[pick*ALU_OP_NUM_BITS +: ALU_OP_NUM_BITS];
                        grant  <= pick;
                        rr_ptr <= (pick == IDXW'(NUM_REQ - 1)) ? '0 : pick + IDXW'(1);
                    end
                end
                ARB_ISSUE: begin
                    rsp_result <= alu_result;
                    rsp_z      <= alu_z;
                    rsp_valid  <= NUM_REQ'(1) << grant;
                end
                ARB_RESP: begin
                    if (rsp_ready[grant]) begin
                        rsp_valid <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
